// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: finds byte alignment from idle commas, locks after
// LOCK_COUNT consecutive aligned commas, then presents every received byte.
module serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  localparam int unsigned BcW = $clog2(LOCK_COUNT) + 1;

  typedef enum logic [1:0] {StHunt, StAlign, StActive} state_e;

  state_e         state_q, state_d;
  logic [7:0]     sr_q, sr_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BcW-1:0] bc_cnt_q, bc_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           active_q, active_d;
  logic           strobe_q, strobe_d;
  logic           is_comma, boundary, lock_hit;

  always_comb begin
    sr_d      = {sr_q[6:0], data_in};
    is_comma  = (sr_d == COMMA);
    boundary  = (bit_cnt_q == 3'd7);
    lock_hit  = ((32'(bc_cnt_q) + 32'd1) == LOCK_COUNT);
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    strobe_d  = 1'b0;

    unique case (state_q)
      StHunt: begin
        // Bit-granular search; the cycle after a match starts a fresh aligned byte.
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          state_d  = StAlign;
          bc_cnt_d = BcW'(1);
        end
      end
      StAlign: begin
        if (boundary) begin
          if (is_comma && lock_hit) begin
            state_d  = StActive;
            bc_cnt_d = '0;
            active_d = 1'b1;
            data_d   = COMMA;
            valid_d  = 1'b0;
            strobe_d = 1'b1;
          end else if (is_comma) begin
            bc_cnt_d = bc_cnt_q + BcW'(1);
          end else begin
            state_d  = StHunt;
            bc_cnt_d = '0;
          end
        end
      end
      StActive: begin
        if (boundary) begin
          data_d   = sr_d;
          valid_d  = !is_comma;
          strobe_d = 1'b1;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= StHunt;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign active      = active_q;
  assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboard bench for serial_paralelo: default instance (0xBC, lock 4) and a
// second instance with COMMA=0x7C, LOCK_COUNT=2, driven by independent bit streams.
module tb_serial_paralelo;

  typedef struct packed {
    int         cyc;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din0 = 1'b0, din1 = 1'b0;
  logic [7:0] dout0, dout1;
  logic       valid0, valid1, active0, active1, strobe0, strobe1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  bit   bq0[$];
  bit   bq1[$];

  // Reference model state per stream: 0 = searching, 1 = counting commas, 2 = locked.
  logic [7:0] win[2];
  int         mode[2];
  int         nbits[2];
  int         ncom[2];
  logic [7:0] cm[2];
  int         lk[2];
  logic [7:0] held_d[2];
  logic       held_v[2];

  serial_paralelo u_dut0 (
    .clk_32f    (clk),
    .reset      (reset),
    .data_in    (din0),
    .data_out   (dout0),
    .valid_out  (valid0),
    .active     (active0),
    .byte_strobe(strobe0)
  );

  serial_paralelo #(
    .COMMA     (8'h7C),
    .LOCK_COUNT(2)
  ) u_dut1 (
    .clk_32f    (clk),
    .reset      (reset),
    .data_in    (din1),
    .data_out   (dout1),
    .valid_out  (valid1),
    .active     (active1),
    .byte_strobe(strobe1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic sb_push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic sb_peek(input int d, output bit have, output exp_t e);
    have = 1'b0;
    e    = '0;
    if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
    if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      win[d]    = 8'h00;
      mode[d]   = 0;
      nbits[d]  = 0;
      ncom[d]   = 0;
      held_d[d] = 8'h00;
      held_v[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int d, input logic b, input int cyc_next);
    exp_t e;
    win[d] = {win[d][6:0], b};
    if (mode[d] == 0) begin
      if (win[d] == cm[d]) begin
        mode[d]  = 1;
        ncom[d]  = 1;
        nbits[d] = 0;
      end
    end else begin
      nbits[d]++;
      if (nbits[d] == 8) begin
        nbits[d] = 0;
        if (mode[d] == 2) begin
          e = '{cyc: cyc_next, data: win[d], valid: (win[d] != cm[d])};
          sb_push(d, e);
        end else if (win[d] == cm[d]) begin
          ncom[d]++;
          if (ncom[d] == lk[d]) begin
            mode[d] = 2;
            e = '{cyc: cyc_next, data: cm[d], valid: 1'b0};
            sb_push(d, e);
          end
        end else begin
          mode[d] = 0;
        end
      end
    end
  endtask

  task automatic load(input int d, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (d == 0) bq0.push_back(v[i]);
      else bq1.push_back(v[i]);
    end
  endtask

  task automatic load_bit(input int d, input bit b);
    if (d == 0) bq0.push_back(b);
    else bq1.push_back(b);
  endtask

  task automatic tick(input logic r);
    logic b0, b1;
    @(negedge clk);
    b0 = (bq0.size() > 0) ? logic'(bq0.pop_front()) : 1'($urandom_range(0, 1));
    b1 = (bq1.size() > 0) ? logic'(bq1.pop_front()) : 1'($urandom_range(0, 1));
    din0  = b0;
    din1  = b1;
    reset = r;
    if (!r) begin
      model_reset();
      #1;
      chk("rst_out0", {dout0, valid0, active0, strobe0}, 32'h0);
      chk("rst_out1", {dout1, valid1, active1, strobe1}, 32'h0);
    end else begin
      model_step(0, b0, cyc + 1);
      model_step(1, b1, cyc + 1);
    end
  endtask

  task automatic run();
    while (bq0.size() > 0 || bq1.size() > 0) tick(1'b1);
  endtask

  task automatic check_dut(input int d, input logic [7:0] dout, input logic v, input logic a,
                           input logic s);
    exp_t e;
    bit   have;
    chk($sformatf("active%0d", d), {31'h0, a}, {31'h0, logic'(mode[d] == 2)});
    sb_peek(d, have, e);
    if (s === 1'b1) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL strobe%0d cyc %0d got unexpected strobe data %0h expected none", d, cyc,
                 dout);
      end else begin
        sb_pop(d);
        if (e.cyc != cyc || dout !== e.data || v !== e.valid) begin
          errors++;
          $display("FAIL byte%0d got cyc %0d data %0h valid %b expected cyc %0d data %0h valid %b",
                   d, cyc, dout, v, e.cyc, e.data, e.valid);
        end
        held_d[d] = e.data;
        held_v[d] = e.valid;
      end
    end else begin
      if (have && e.cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL strobe%0d got no strobe at cyc %0d expected byte %0h", d, cyc, e.data);
        sb_pop(d);
      end
      chk($sformatf("hold%0d", d), {23'h0, dout, v}, {23'h0, held_d[d], held_v[d]});
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc++;
    check_dut(0, dout0, valid0, active0, strobe0);
    check_dut(1, dout1, valid1, active1, strobe1);
  end

  initial begin
    logic [7:0] rb;
    cm[0] = 8'hBC; lk[0] = 4;
    cm[1] = 8'h7C; lk[1] = 2;
    model_reset();

    // Reset held with random data, then partial lock abandoned by a mid-byte reset.
    repeat (3) tick(1'b0);
    load(0, 8'hBC); load(0, 8'hBC); load_bit(0, 1); load_bit(0, 0); load_bit(0, 1);
    load(1, 8'h7C); load_bit(1, 1); load_bit(1, 1); load_bit(1, 0);
    run();
    tick(1'b0);
    tick(1'b0);

    // Junk bits then fresh commas: lock on the LSB of the last required comma.
    load_bit(0, 1); load_bit(0, 0); load_bit(0, 1);
    for (int i = 0; i < 4; i++) load(0, 8'hBC);
    load_bit(1, 1); load_bit(1, 0); load_bit(1, 1);
    for (int i = 0; i < 2; i++) load(1, 8'h7C);
    run();
    @(posedge clk);
    #2;
    chk("lock_active0", {31'h0, active0}, 32'h1);
    chk("lock_strobe0", {31'h0, strobe0}, 32'h1);
    chk("lock_byte0", {23'h0, dout0, valid0}, {23'h0, 8'hBC, 1'b0});
    chk("lock_active1", {31'h0, active1}, 32'h1);

    // Data, then idle commas inside ACTIVE.
    load(0, 8'hFF); load(0, 8'hEE); load(0, 8'h9D);
    load(1, 8'h7C); load(1, 8'hA5); load(1, 8'h55);
    run();
    load(0, 8'h9D); load(0, 8'hBC); load(0, 8'hAF);
    load(1, 8'h7C); load(1, 8'hBC); load(1, 8'h7C);
    run();
    @(posedge clk);
    #2;
    chk("idle_byte0", {23'h0, dout0, valid0}, {23'h0, 8'hAF, 1'b1});
    chk("idle_byte1", {23'h0, dout1, valid1}, {23'h0, 8'h7C, 1'b0});
    chk("idle_active0", {31'h0, active0}, 32'h1);

    // Broken lock after reset: a non-comma boundary byte sends the search back.
    tick(1'b0);
    load(0, 8'hBC); load(0, 8'hBC); load(0, 8'h3C);
    load(1, 8'h7C); load(1, 8'h3C); load(1, 8'h3C);
    run();
    @(posedge clk);
    #2;
    chk("broken_active0", {31'h0, active0}, 32'h0);
    for (int i = 0; i < 4; i++) load(0, 8'hBC);
    load(1, 8'h7C); load(1, 8'h7C);
    run();
    @(posedge clk);
    #2;
    chk("relock_active0", {31'h0, active0}, 32'h1);

    // Random traffic with frequent commas, including a few more resets.
    for (int r = 0; r < 3; r++) begin
      tick(1'b0);
      for (int i = 0; i < 4; i++) begin
        load(0, 8'hBC);
        load(1, 8'h7C);
      end
      for (int i = 0; i < 30; i++) begin
        rb = 8'($urandom);
        load(0, ($urandom_range(0, 3) == 0) ? 8'hBC : rb);
        rb = 8'($urandom);
        load(1, ($urandom_range(0, 3) == 0) ? 8'h7C : rb);
      end
      run();
    end
    @(posedge clk);
    #2;
    chk("sb_empty0", q0.size(), 32'h0);
    chk("sb_empty1", q1.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
